// File: rtl/midi_pkg.sv
// Shared MIDI constants, parser state encoding and message types.
package midi_pkg;

  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] POLY_AT  = 4'hA;
  localparam logic [3:0] CTRL     = 4'hB;
  localparam logic [3:0] PROG     = 4'hC;
  localparam logic [3:0] CHAN_AT  = 4'hD;
  localparam logic [3:0] PITCH    = 4'hE;

  localparam logic [7:0] SYS_EX    = 8'hF0;
  localparam logic [7:0] SYS_MTC   = 8'hF1;
  localparam logic [7:0] SYS_SPP   = 8'hF2;
  localparam logic [7:0] SYS_SONG  = 8'hF3;
  localparam logic [7:0] SYS_TUNE  = 8'hF6;
  localparam logic [7:0] SYS_EOX   = 8'hF7;
  localparam logic [7:0] SYS_CLOCK = 8'hF8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_D1,
    ST_WAIT_D2,
    ST_SYSEX
  } state_t;

  typedef logic [1:0] len_t;

endpackage

// File: rtl/midi_len_decode.sv
// Status byte -> data length and class flags. Purely combinational.
module midi_len_decode
  import midi_pkg::*;
(
  input  logic [7:0] status,
  output len_t       len,
  output logic       is_sys_common,
  output logic       is_realtime
);

  always_comb begin
    len           = 2'd0;
    is_sys_common = 1'b0;
    is_realtime   = (status >= SYS_CLOCK);
    if (status[7:4] != 4'hF) begin
      case (status[7:4])
        NOTE_OFF, NOTE_ON, POLY_AT, CTRL, PITCH: len = 2'd2;
        PROG, CHAN_AT:                           len = 2'd1;
        default:                                 len = 2'd0;
      endcase
    end else begin
      case (status)
        SYS_MTC, SYS_SONG: begin len = 2'd1; is_sys_common = 1'b1; end
        SYS_SPP:           begin len = 2'd2; is_sys_common = 1'b1; end
        default:           len = 2'd0;
      endcase
    end
  end

endmodule

// File: rtl/midi_msg_parser.sv
// MIDI byte stream -> complete messages with running status; real-time bypass.
// All pulses 1 cycle after the causing strobe; no backpressure, one byte per cycle.
module midi_msg_parser
  import midi_pkg::*;
#(
  parameter int BYTE_W      = 8,
  parameter bit VEL0_IS_OFF = 1'b1
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] byte_in,
  input  logic              is_command,
  input  logic              byte_strobe,
  output logic              msg_valid,
  output logic [7:0]        msg_status,
  output logic [6:0]        msg_d1,
  output logic [6:0]        msg_d2,
  output logic              rt_valid,
  output logic [7:0]        rt_byte,
  output logic              err_pulse
);

  state_t     state;
  logic [7:0] run_status;
  len_t       run_len;
  logic       run_sys;
  logic       fresh;
  logic [6:0] d1_q;

  len_t       len;
  logic       is_sys;
  logic       is_rt;
  logic [7:0] d2_status;

  midi_len_decode u_len (
    .status        (byte_in),
    .len           (len),
    .is_sys_common (is_sys),
    .is_realtime   (is_rt)
  );

  // Zero-velocity Note-On is reported as Note-Off; running status is unaffected.
  always_comb begin
    d2_status = run_status;
    if (VEL0_IS_OFF && run_status[7:4] == NOTE_ON && byte_in[6:0] == 7'd0)
      d2_status = {NOTE_OFF, run_status[3:0]};
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      run_status <= '0;
      run_len    <= '0;
      run_sys    <= 1'b0;
      fresh      <= 1'b0;
      d1_q       <= '0;
      msg_valid  <= 1'b0;
      msg_status <= '0;
      msg_d1     <= '0;
      msg_d2     <= '0;
      rt_valid   <= 1'b0;
      rt_byte    <= '0;
      err_pulse  <= 1'b0;
    end else begin
      msg_valid <= 1'b0;
      rt_valid  <= 1'b0;
      err_pulse <= 1'b0;
      if (byte_strobe) begin
        if (is_command && is_rt) begin
          rt_valid <= 1'b1;
          rt_byte  <= byte_in;
        end else if (is_command) begin
          // A status cutting into an unfinished message is an error, then taken normally.
          err_pulse  <= (state == ST_WAIT_D2) || (state == ST_WAIT_D1 && fresh);
          run_status <= byte_in;
          run_len    <= len;
          run_sys    <= is_sys;
          fresh      <= 1'b1;
          if (len != 2'd0) begin
            state <= ST_WAIT_D1;
          end else begin
            state <= ST_IDLE;
            if (byte_in == SYS_EX) begin
              state <= ST_SYSEX;
            end else if (byte_in == SYS_TUNE) begin
              msg_valid  <= 1'b1;
              msg_status <= byte_in;
              msg_d1     <= '0;
              msg_d2     <= '0;
            end
          end
        end else begin
          case (state)
            ST_IDLE: err_pulse <= 1'b1;
            ST_WAIT_D1: begin
              d1_q  <= byte_in[6:0];
              fresh <= 1'b0;
              if (run_len == 2'd1) begin
                msg_valid  <= 1'b1;
                msg_status <= run_status;
                msg_d1     <= byte_in[6:0];
                msg_d2     <= '0;
                state      <= run_sys ? ST_IDLE : ST_WAIT_D1;
              end else begin
                state <= ST_WAIT_D2;
              end
            end
            ST_WAIT_D2: begin
              msg_valid  <= 1'b1;
              msg_status <= d2_status;
              msg_d1     <= d1_q;
              msg_d2     <= byte_in[6:0];
              state      <= run_sys ? ST_IDLE : ST_WAIT_D1;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_midi_msg_parser.sv
// Randomized scoreboard bench for midi_msg_parser against a message-level reference model.
module tb_midi_msg_parser;

  logic       sys_clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] byte_in = '0;
  logic       is_command = 1'b0;
  logic       byte_strobe = 1'b0;
  logic       msg_valid;
  logic [7:0] msg_status;
  logic [6:0] msg_d1;
  logic [6:0] msg_d2;
  logic       rt_valid;
  logic [7:0] rt_byte;
  logic       err_pulse;

  midi_msg_parser #(.BYTE_W(8), .VEL0_IS_OFF(1'b1)) dut (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .byte_in     (byte_in),
    .is_command  (is_command),
    .byte_strobe (byte_strobe),
    .msg_valid   (msg_valid),
    .msg_status  (msg_status),
    .msg_d1      (msg_d1),
    .msg_d2      (msg_d2),
    .rt_valid    (rt_valid),
    .rt_byte     (rt_byte),
    .err_pulse   (err_pulse)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct {
    bit         msg;
    logic [7:0] st;
    logic [6:0] d1;
    logic [6:0] d2;
    bit         rt;
    logic [7:0] rtb;
    bit         err;
    int         at;
  } exp_t;

  exp_t exp_q[$];
  int compared = 0;
  int mismatched = 0;

  logic [7:0] held_st = '0;
  logic [6:0] held_d1 = '0;
  logic [6:0] held_d2 = '0;
  logic [7:0] held_rtb = '0;

  // Reference model: current status (-1 = none), collected data bytes, sysex flag.
  int  m_cur = -1;
  bit  m_fresh = 0;
  bit  m_sysex = 0;
  int  m_got[$];

  function automatic int data_len(int s);
    if (s < 8'hF0) return (s / 16 == 12 || s / 16 == 13) ? 1 : 2;
    if (s == 8'hF1 || s == 8'hF3) return 1;
    if (s == 8'hF2) return 2;
    return 0;
  endfunction

  function automatic void model_reset();
    m_cur = -1;
    m_fresh = 0;
    m_sysex = 0;
    m_got.delete();
  endfunction

  function automatic exp_t model_byte(int b);
    exp_t e;
    int n;
    e = '{msg: 0, st: 0, d1: 0, d2: 0, rt: 0, rtb: 0, err: 0, at: 0};
    if (b >= 8'hF8) begin
      e.rt = 1; e.rtb = 8'(b);
    end else if (b >= 8'h80) begin
      e.err = (m_cur >= 0) && (m_fresh || m_got.size() > 0);
      m_got.delete();
      m_sysex = 0;
      m_cur = -1;
      if (data_len(b) > 0) begin
        m_cur = b; m_fresh = 1;
      end else if (b == 8'hF0) begin
        m_sysex = 1;
      end else if (b == 8'hF6) begin
        e.msg = 1; e.st = 8'hF6;
      end
    end else if (!m_sysex) begin
      if (m_cur < 0) begin
        e.err = 1;
      end else begin
        m_got.push_back(b);
        m_fresh = 0;
        n = data_len(m_cur);
        if (m_got.size() == n) begin
          e.msg = 1;
          e.st = 8'(m_cur);
          e.d1 = 7'(m_got[0]);
          if (n == 2) e.d2 = 7'(m_got[1]);
          if (n == 2 && m_cur / 16 == 9 && m_got[1] == 0) e.st = 8'(m_cur - 16);
          m_got.delete();
          if (m_cur >= 8'hF0) m_cur = -1;
        end
      end
    end
    return e;
  endfunction

  task automatic send(input int b);
    exp_t e;
    @(posedge sys_clk); #1;
    byte_in = 8'(b);
    is_command = (b >= 8'h80);
    byte_strobe = 1'b1;
    e = model_byte(b);
    e.at = cyc + 1;
    if (e.msg || e.rt || e.err) exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge sys_clk); #1;
      byte_strobe = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    compared++;
    if ({msg_valid, msg_status, msg_d1, msg_d2, rt_valid, rt_byte, err_pulse} != '0) begin
      mismatched++;
      $display("FAIL %s: outputs after reset got %b/%h/%h/%h/%b/%h/%b, want all zero", tag,
               msg_valid, msg_status, msg_d1, msg_d2, rt_valid, rt_byte, err_pulse);
    end
  endtask

  // Reset with an optional coincident strobe whose byte must be lost.
  task automatic do_reset(input bit with_byte, input int b);
    @(posedge sys_clk); #1;
    rst = 1'b1;
    byte_strobe = with_byte;
    byte_in = 8'(b);
    is_command = (b >= 8'h80);
    @(posedge sys_clk); #1;
    rst = 1'b0;
    byte_strobe = 1'b0;
    model_reset();
    held_st = '0; held_d1 = '0; held_d2 = '0; held_rtb = '0;
    check_reset_outputs(with_byte ? "reset_with_strobe" : "reset");
  endtask

  // Monitor: every cycle the outputs are compared with the next expected pulse or the held values.
  always @(negedge sys_clk) begin
    exp_t e;
    logic [38:0] got, want;
    got = {msg_valid, msg_status, msg_d1, msg_d2, rt_valid, rt_byte, err_pulse};
    if (msg_valid || rt_valid || err_pulse) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_pulse @%0d: got msg=%b st=%h d1=%h d2=%h rt=%b rtb=%h err=%b, want no pulse",
                 cyc, msg_valid, msg_status, msg_d1, msg_d2, rt_valid, rt_byte, err_pulse);
      end else begin
        e = exp_q.pop_front();
        if (e.msg) begin held_st = e.st; held_d1 = e.d1; held_d2 = e.d2; end
        if (e.rt) held_rtb = e.rtb;
        want = {e.msg, held_st, held_d1, held_d2, e.rt, held_rtb, e.err};
        if (got != want || cyc != e.at) begin
          mismatched++;
          $display("FAIL pulse @%0d: got msg=%b st=%h d1=%h d2=%h rt=%b rtb=%h err=%b, want @%0d msg=%b st=%h d1=%h d2=%h rt=%b rtb=%h err=%b",
                   cyc, msg_valid, msg_status, msg_d1, msg_d2, rt_valid, rt_byte, err_pulse,
                   e.at, e.msg, held_st, held_d1, held_d2, e.rt, held_rtb, e.err);
        end
      end
    end else if (!rst) begin
      compared++;
      want = {1'b0, held_st, held_d1, held_d2, 1'b0, held_rtb, 1'b0};
      if (got != want || (exp_q.size() > 0 && exp_q[0].at <= cyc)) begin
        mismatched++;
        $display("FAIL hold @%0d: got st=%h d1=%h d2=%h rtb=%h, want st=%h d1=%h d2=%h rtb=%h (pending=%0d)",
                 cyc, msg_status, msg_d1, msg_d2, rt_byte, held_st, held_d1, held_d2, held_rtb, exp_q.size());
        if (exp_q.size() > 0 && exp_q[0].at <= cyc) void'(exp_q.pop_front());
      end
    end
  end

  function automatic int rand_byte();
    case ($urandom_range(0, 11))
      0, 1, 2, 3: return ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 127));
      4:          return int'($urandom_range(8, 14)) * 16 + int'($urandom_range(0, 15));
      5:          return 8'h90 + int'($urandom_range(0, 15));
      6:          return int'($urandom_range(8'hF8, 8'hFF));
      7:          return ($urandom_range(0, 1) == 1) ? 8'hF0 : 8'hF7;
      8:          return int'($urandom_range(8'hF1, 8'hF6));
      default:    return int'($urandom_range(0, 127));
    endcase
  endfunction

  initial begin
    int b;
    repeat (3) @(posedge sys_clk);
    #1;
    rst = 1'b0;
    check_reset_outputs("initial_reset");

    // Directed sequences from the behaviour description.
    send(8'h90); send(8'h3C); send(8'h64); idle(2);
    send(8'h40); send(8'h00); idle(2);
    do_reset(1'b0, 0);
    send(8'h12); send(8'hC5); send(8'h07); send(8'h09); idle(2);
    send(8'h90); send(8'h3C); send(8'hF8); send(8'h64); idle(2);
    send(8'hF0); send(8'h7E); send(8'h01); send(8'h02); send(8'hF7); send(8'h45); idle(2);
    send(8'hF0); send(8'h01); send(8'hB0); send(8'h07); send(8'h7F); idle(2);
    send(8'hB0); send(8'h07); send(8'hE0); send(8'h00); send(8'h40); idle(2);
    send(8'hF2); send(8'h11); send(8'h22); send(8'h33); send(8'hF6); send(8'hF4); send(8'h01); idle(2);
    send(8'h90); send(8'h3C);
    do_reset(1'b0, 0);
    send(8'h64); idle(2);
    send(8'hA1); send(8'h10);
    do_reset(1'b1, 8'h20);
    send(8'h20); idle(2);

    // Randomized traffic with gaps and occasional resets.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset($urandom_range(0, 1) == 1, rand_byte());
      end else begin
        b = rand_byte();
        send(b);
        if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      end
    end
    idle(1);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge sys_clk);
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      compared++;
      mismatched++;
      $display("FAIL missing_pulse: got none, want @%0d msg=%b st=%h d1=%h d2=%h rt=%b rtb=%h err=%b",
               e.at, e.msg, e.st, e.d1, e.d2, e.rt, e.rtb, e.err);
    end
    @(posedge sys_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
